// File: rtl/wb_flash_arbiter.sv
// wb_flash_arbiter: two-master Wishbone arbiter for the shared QSPI flash slave.
module wb_flash_arbiter #(
  parameter int AW        = 24,
  parameter int DW        = 32,
  parameter int MAX_BURST = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_reset_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic [DW-1:0]   m0_dat_o,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_stb_i,
  input  logic            m0_cyc_i,
  output logic            m0_ack_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic [DW-1:0]   m1_dat_o,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_stb_i,
  input  logic            m1_cyc_i,
  output logic            m1_ack_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  output logic [1:0]      grant_o
);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, HANDOVER} state_t;
  localparam int BW = $clog2(MAX_BURST + 1);
  state_t state_q, state_d;
  logic [BW-1:0] burst_q, burst_d, burst_inc;
  logic last_q, last_d;
  logic req0, req1, g0, g1, lim, pick1;
  assign req0 = m0_cyc_i & m0_stb_i;
  assign req1 = m1_cyc_i & m1_stb_i;
  assign g0 = state_q == GRANT0;
  assign g1 = state_q == GRANT1;
  assign grant_o = {g1, g0};
  assign lim = burst_q >= BW'(MAX_BURST - 1);
  assign burst_inc = (burst_q == BW'(MAX_BURST)) ? burst_q : burst_q + BW'(1);
  // last_q set means m1 was granted most recently, so m0 wins a tie
  assign pick1 = req1 & (!req0 | !last_q);
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = s_ack_i & g0;
  assign m1_ack_o = s_ack_i & g1;
  assign s_adr_o = g1 ? m1_adr_i : m0_adr_i;
  assign s_dat_o = g1 ? m1_dat_i : m0_dat_i;
  assign s_we_o  = g1 ? m1_we_i : m0_we_i;
  assign s_sel_o = g1 ? m1_sel_i : m0_sel_i;
  assign s_cyc_o = g0 ? m0_cyc_i : g1 ? m1_cyc_i : 1'b0;
  assign s_stb_o = g0 ? m0_stb_i : g1 ? m1_stb_i : 1'b0;
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    last_d  = last_q;
    case (state_q)
      IDLE: if (req0 | req1) begin
        state_d = pick1 ? GRANT1 : GRANT0;
        burst_d = '0;
        last_d  = pick1;
      end
      GRANT0: begin
        burst_d = s_ack_i ? burst_inc : burst_q;
        state_d = !m0_cyc_i ? IDLE : (s_ack_i & lim & req1) ? HANDOVER : GRANT0;
      end
      GRANT1: begin
        burst_d = s_ack_i ? burst_inc : burst_q;
        state_d = !m1_cyc_i ? IDLE : (s_ack_i & lim & req0) ? HANDOVER : GRANT1;
      end
      HANDOVER: if (last_q ? req0 : req1) begin
        state_d = last_q ? GRANT0 : GRANT1;
        burst_d = '0;
        last_d  = !last_q;
      end else state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_reset_i) begin
      state_q <= IDLE;
      burst_q <= '0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      last_q  <= last_d;
    end
  end
endmodule
